serial_add_sub: RTL

Parametrised bit-serial adder/subtractor and the sequential successor to the single-bit half adder/subtractor cells. It accepts two WIDTH-bit operands and a mode bit on a start strobe. It processes one bit per clock, LSB first, through a single full-adder slice with a registered carry. It then reports the result, carry/borrow and signed overflow with a one-cycle done pulse. It serves as the area-minimal arithmetic unit for datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/serial_arith_pkg.sv | 23 ++
 rtl/full_adder_cell.sv | 19 +
 rtl/serial_add_sub.sv | 99 +++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and constants for the bit-serial arithmetic unit
package serial_arith_pkg;

  // FSM encoding kept as plain constants so older blocks can share it
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bits needed to count 0..value-1
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - one-bit full adder built from two half-adder stages
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic hs1_sum, hs1_carry, hs2_carry;

  // First half adder combines the operands, second folds in the carry
  assign hs1_sum   = a ^ b;
  assign hs1_carry = a & b;
  assign sum       = hs1_sum ^ cin;
  assign hs2_carry = hs1_sum & cin;
  assign cout      = hs1_carry | hs2_carry;

endmodule

// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - bit-serial adder/subtractor, LSB first, one bit per clock
module serial_add_sub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             carry_q;
  logic             mode_q;
  logic             fa_sum;
  logic             fa_cout;

  // Single serial slice; subtraction arrives as a + ~b + 1 via the preset carry
  full_adder_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Status outputs decode straight from the state register
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // FSM, datapath shift registers and flag capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      bit_cnt   <= '0;
      carry_q   <= 1'b0;
      mode_q    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            a_sr      <= a;
            b_sr      <= (mode == MODE_ADD) ? b : ~b;
            mode_q    <= mode;
            carry_q   <= mode;
            bit_cnt   <= '0;
            res_sr    <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        RUN: begin
          a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr  <= {fa_sum, res_sr[WIDTH-1:1]};
          carry_q <= fa_cout;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            // carry_q is the carry into the MSB on this final edge
            state     <= DONE;
            result    <= {fa_sum, res_sr[WIDTH-1:1]};
            carry_out <= fa_cout ^ mode_q;
            overflow  <= carry_q ^ fa_cout;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
